fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write-port arbiter that lets NUM_REQ independent producers share the single write port of one synchronous FIFO (the fifo_sync block). Each producer presents beats over a valid/ready handshake. The arbiter locks a grant to one producer for a burst, forwards its beats to the FIFO write port, and never issues a write while the FIFO reports full. It sits directly in front of the FIFO and is the only driver of the FIFO's i_wr and i_data.

## Interface
- NUM_REQ, 4: number of producers, 2..8
- DATA_WIDTH, 32: beat width; must match the FIFO
- MAX_BURST, 4: maximum beats per grant, 1..16
- i_clk  in  1  clock; all logic is rising-edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_req_valid  in  NUM_REQ  per-producer beat valid
- i_req_data  in  NUM_REQ*DATA_WIDTH  producer k's beat is bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_req_last  in  NUM_REQ  marks the final beat of a producer's burst
- o_req_ready  out  NUM_REQ  per-producer ready; at most one bit high
- o_fifo_data  out  DATA_WIDTH  connects to FIFO i_data
- o_fifo_wr  out  1  connects to FIFO i_wr
- i_fifo_full  in  1  FIFO o_full (registered in the FIFO)
- o_grant  out  NUM_REQ  one-hot registered grant; 0 when idle
- o_busy  out  1  high while in GRANT

## Operation
- FSM states: IDLE and GRANT; 1-bit state register.
- IDLE:
  - o_req_ready = 0.
  - If any i_req_valid is set, select the winner round-robin: search starts at (last_grant+1) mod NUM_REQ and ascends with wrap.
  - Next edge: o_grant = onehot(winner), last_grant = winner, beat_cnt = 0, state = GRANT.
  - No beat transfers in IDLE.
- GRANT (granted index g):
  - o_req_ready[g] = !i_fifo_full; all other ready bits are 0.
  - A beat transfers when i_req_valid[g] && o_req_ready[g].
  - On transfer: o_fifo_wr = 1 and o_fifo_data = producer g's data slice. Both are combinational from inputs and state.
  - On each transfer, beat_cnt increments (width clog2(MAX_BURST)+1).
  - Release to IDLE on the edge after a transfer that has i_req_last[g] set, or that brings beat_cnt+1 to MAX_BURST. On release, o_grant is cleared.
  - i_req_valid[g] low holds the grant with no write and no timeout. A producer that asserts valid must eventually complete its burst.
- o_fifo_wr is never asserted while i_fifo_full = 1. This is mandatory: the FIFO advances wptr on every i_wr.
- When o_fifo_wr = 0, o_fifo_data is don't-care; drive 0.
- Producers must hold data and last stable while valid && !ready.
- Reset mid-burst: the grant is dropped immediately and the FSM returns to IDLE. Partial bursts are not resumed.

## Timing
- Reset values:
  - state IDLE, o_grant 0, o_busy 0, o_req_ready 0, o_fifo_wr 0, o_fifo_data 0.
  - last_grant = NUM_REQ-1, so producer 0 wins first.
  - beat_cnt 0.
- Arbitration latency: 1 cycle from valid seen in IDLE to GRANT. The first beat can transfer in the first GRANT cycle.
- Throughput: 1 beat/cycle within a burst. Each new burst costs 1 idle cycle, so with MAX_BURST=4 all-busy throughput is 4/5.
- Full back-pressure: i_fifo_full rising stalls transfers in the same cycle, and the grant is kept. Transfer resumes in the first cycle i_fifo_full is 0.
- A MAX_BURST=1 grant releases after every beat.

## Configuration
- FIFO_WR_ARB_STATS_EN defined:
  - Adds output o_stall_cnt (16 bits).
  - It is a saturating count of cycles in GRANT with i_req_valid[g] && i_fifo_full.
  - Reset to 0; it holds at 16'hFFFF.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Package fifo_wr_arb_pkg holds:
  - the state enum (ST_IDLE, ST_GRANT);
  - the localparam functions for beat_cnt width and grant-index width.
- Sub-module rr_pick: combinational rotate-priority encoder. It takes the request vector and last_grant, and returns winner index plus any-valid. It is instantiated once.

## Test plan
- Single producer: reset, then producer 1 sends 3 beats with last on the third, FIFO never full. Required: o_grant=4'b0010 one cycle after valid, 3 consecutive o_fifo_wr pulses with correct data, then o_grant=0.
- All four valid continuously, last never set, MAX_BURST=4. Required: grant order 0,1,2,3,0. Each grant carries exactly 4 writes, with a 1-cycle gap between grants.
- i_fifo_full forced high for 3 cycles mid-burst. Required: o_req_ready and o_fifo_wr are 0 for exactly those cycles, the grant is unchanged, and no beat is lost or duplicated.
- Granted producer drops valid for 2 cycles. Required: the grant is held, no writes occur, and the burst completes after valid returns.
- i_rstn pulled low after the second beat of a burst. Required: all outputs return to reset values asynchronously, and the next grant goes to producer 0.
- Back-to-back arbitration: producer 3 is granted, then producers 0 and 2 request. Required: producer 0 wins, because the search starts at 0 after 3.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and width helpers for the fifo_wr_arb write-port arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Wide enough to hold MAX_BURST itself, not just MAX_BURST-1.
  function automatic int unsigned cnt_width(int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  function automatic int unsigned idx_width(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after (last+1) mod NUM_REQ, with wrap.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any
);

  int unsigned       pos;
  logic [IDX_W-1:0]  idx;

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    pos      = 0;
    idx      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      pos = (32'(i_last) + i) % NUM_REQ;
      idx = IDX_W'(pos);
      if (!o_any && i_req[idx]) begin
        o_any    = 1'b1;
        o_winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional stall counter output enabled by FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  output logic                          o_fifo_wr,
  input  logic                          i_fifo_full,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [15:0]                   o_stall_cnt,
`endif
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int unsigned CNT_W = cnt_width(MAX_BURST);
  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [CNT_W-1:0]   beat_cnt_q;

  logic [IDX_W-1:0]   winner;
  logic               any_valid;
  logic               in_grant;
  logic               xfer;
  logic               release_burst;
  int unsigned        gidx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req    (i_req_valid),
    .i_last   (last_grant_q),
    .o_winner (winner),
    .o_any    (any_valid)
  );

  // last_grant_q doubles as the index of the current grant while in ST_GRANT.
  always_comb begin
    gidx          = 32'(last_grant_q);
    in_grant      = (state_q == ST_GRANT);
    o_req_ready   = '0;
    if (in_grant && !i_fifo_full) o_req_ready = grant_q;
    xfer          = in_grant && i_req_valid[last_grant_q] && !i_fifo_full;
    o_fifo_wr     = xfer;
    o_fifo_data   = xfer ? i_req_data[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
    release_burst = xfer && (i_req_last[last_grant_q] ||
                             ((beat_cnt_q + 1'b1) == CNT_W'(MAX_BURST)));
    o_grant       = grant_q;
    o_busy        = in_grant;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            state_q      <= ST_GRANT;
            grant_q      <= NUM_REQ'(1) << winner;
            last_grant_q <= winner;
            beat_cnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (release_burst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_q <= '0;
    end else if (in_grant && i_req_valid[last_grant_q] && i_fifo_full &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [DW-1:0] fifo_data;
  logic          fifo_wr;
  logic          fifo_full;
  logic [NR-1:0] grant;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arb #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_fifo_data (fifo_data),
    .o_fifo_wr   (fifo_wr),
    .i_fifo_full (fifo_full),
    .o_grant     (grant),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive and check in the low phase, away from the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input int k, input logic [31:0] d, input logic last);
    req_data[k*DW +: DW] = d;
    req_last[k]          = last;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic wr,
                         input logic [31:0] d, input logic [3:0] rdy);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".wr"},    32'(fifo_wr), 32'(wr));
    chk({tag, ".data"},  fifo_data, d);
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
  endtask

  task automatic do_reset();
    step();
    rstn = 1'b0;
    #1;
    step();
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    #12;
    chk_out("rst", 4'b0000, 1'b0, 32'h0, 4'b0000);
    chk("rst.busy", 32'(busy), 32'd0);

    // Single producer 1, three beats, last on the third.
    step(); rstn = 1'b1;
    step(); req_valid = 4'b0010; beat(1, 32'h1100_0000, 1'b0); #1;
    chk_out("t1.idle", 4'b0000, 1'b0, 32'h0, 4'b0000);
    step(); #1;
    chk_out("t1.b0", 4'b0010, 1'b1, 32'h1100_0000, 4'b0010);
    chk("t1.busy", 32'(busy), 32'd1);
    step(); beat(1, 32'h1100_0001, 1'b0); #1;
    chk_out("t1.b1", 4'b0010, 1'b1, 32'h1100_0001, 4'b0010);
    step(); beat(1, 32'h1100_0002, 1'b1); #1;
    chk_out("t1.b2", 4'b0010, 1'b1, 32'h1100_0002, 4'b0010);
    step(); req_valid = '0; req_last = '0; #1;
    chk_out("t1.rel", 4'b0000, 1'b0, 32'h0, 4'b0000);
    chk("t1.busy_rel", 32'(busy), 32'd0);

    // All four valid, never last: order 0,1,2,3,0, four beats each, one idle gap.
    do_reset();
    for (int k = 0; k < NR; k++) beat(k, 32'hD000_0000 + 32'(k), 1'b0);
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      automatic int exp_k = n % NR;
      chk($sformatf("t2.gap%0d", n), 32'(fifo_wr) | 32'(grant), 32'd0);
      for (int b = 0; b < 4; b++) begin
        step(); #1;
        chk_out($sformatf("t2.g%0d.b%0d", n, b), 4'(1 << exp_k), 1'b1,
                32'hD000_0000 + 32'(exp_k), 4'(1 << exp_k));
      end
      step();
      if (n == 4) req_valid = '0;
      #1;
    end
    chk("t2.end", 32'(grant), 32'd0);

    // Full for 3 cycles mid-burst on producer 2 (last grant was 0).
    req_valid = 4'b0100; beat(2, 32'h2200_0000, 1'b0);
    step(); #1;
    chk_out("t3.b0", 4'b0100, 1'b1, 32'h2200_0000, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      step(); beat(2, 32'h2200_0001, 1'b0); fifo_full = 1'b1; #1;
      chk_out($sformatf("t3.full%0d", c), 4'b0100, 1'b0, 32'h0, 4'b0000);
    end
    step(); fifo_full = 1'b0; #1;
    chk_out("t3.b1", 4'b0100, 1'b1, 32'h2200_0001, 4'b0100);
    step(); beat(2, 32'h2200_0002, 1'b1); #1;
    chk_out("t3.b2", 4'b0100, 1'b1, 32'h2200_0002, 4'b0100);
    step(); req_valid = '0; req_last = '0; #1;
    chk_out("t3.rel", 4'b0000, 1'b0, 32'h0, 4'b0000);

    // Producer 3 drops valid for 2 cycles; burst ends at MAX_BURST.
    req_valid = 4'b1000; beat(3, 32'h3300_0000, 1'b0);
    step(); #1;
    chk_out("t4.b0", 4'b1000, 1'b1, 32'h3300_0000, 4'b1000);
    for (int c = 0; c < 2; c++) begin
      step(); req_valid = 4'b0000; #1;
      chk_out($sformatf("t4.hold%0d", c), 4'b1000, 1'b0, 32'h0, 4'b1000);
    end
    for (int b = 1; b < 4; b++) begin
      step(); req_valid = 4'b1000; beat(3, 32'h3300_0000 + 32'(b), 1'b0); #1;
      chk_out($sformatf("t4.b%0d", b), 4'b1000, 1'b1, 32'h3300_0000 + 32'(b), 4'b1000);
    end
    // Back-to-back: 0 and 2 request after 3 was granted; 0 wins.
    step(); req_valid = 4'b0101; beat(0, 32'h0A00_0000, 1'b1);
    beat(2, 32'h2A00_0000, 1'b1); #1;
    chk_out("t6.idle", 4'b0000, 1'b0, 32'h0, 4'b0000);
    step(); #1;
    chk_out("t6.p0", 4'b0001, 1'b1, 32'h0A00_0000, 4'b0001);
    step(); req_valid = 4'b0100; #1;
    chk("t6.gap", 32'(grant), 32'd0);
    step(); #1;
    chk_out("t6.p2", 4'b0100, 1'b1, 32'h2A00_0000, 4'b0100);

    // Reset after the second beat of producer 1's burst.
    step(); req_valid = 4'b0010; beat(1, 32'h5500_0000, 1'b0); req_last = '0;
    step(); #1;
    chk_out("t5.b0", 4'b0010, 1'b1, 32'h5500_0000, 4'b0010);
    step(); beat(1, 32'h5500_0001, 1'b0); #1;
    chk_out("t5.b1", 4'b0010, 1'b1, 32'h5500_0001, 4'b0010);
    step(); beat(1, 32'h5500_0002, 1'b0); rstn = 1'b0; #1;
    chk_out("t5.rst", 4'b0000, 1'b0, 32'h0, 4'b0000);
    chk("t5.busy", 32'(busy), 32'd0);
    step(); rstn = 1'b1; req_valid = 4'b0111; beat(0, 32'h0B00_0000, 1'b1); #1;
    step(); #1;
    chk_out("t5.next", 4'b0001, 1'b1, 32'h0B00_0000, 4'b0001);
    step(); req_valid = '0; req_last = '0; #1;

    // Full already high when a grant is taken: grant issues, nothing writes.
    fifo_full = 1'b1; req_valid = 4'b1000; beat(3, 32'h3C00_0000, 1'b1);
    step(); #1;
    chk_out("t7.full", 4'b1000, 1'b0, 32'h0, 4'b0000);
    step(); fifo_full = 1'b0; #1;
    chk_out("t7.go", 4'b1000, 1'b1, 32'h3C00_0000, 4'b1000);
    step(); req_valid = '0; req_last = '0; #1;
    chk("t7.rel", 32'(grant), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
